// File: rtl/udp_rx_if.sv
// Receive-side bus for the UDP/IPv4 receiver: GMII RX byte stream in,
// payload words, packet-done pulse, byte count and source IP out.
interface udp_rx_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic [31:0] src_ip;

    // Frame source side (PHY model / bench)
    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  rec_en, rec_data, rec_pkt_done, rec_byte_num, src_ip
    );

    // Receiver side
    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output rec_en, rec_data, rec_pkt_done, rec_byte_num, src_ip
    );
endinterface

// File: rtl/udp_rx.sv
// GMII (1000M, one byte per clk) UDP/IPv4 receiver. Strips preamble, Ethernet,
// IPv4 and UDP headers, filters on MAC / EtherType / IP / protocol and delivers
// the UDP payload as big-endian 32-bit words. FCS is not checked here.
module udp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd0, 8'd2}
) (
    input  logic clk,
    input  logic rst,
    udp_rx_if.slave bus
);

    typedef enum logic [6:0] {
        st_idle     = 7'b000_0001,
        st_preamble = 7'b000_0010,
        st_eth_head = 7'b000_0100,
        st_ip_head  = 7'b000_1000,
        st_udp_head = 7'b001_0000,
        st_rx_data  = 7'b010_0000,
        st_rx_end   = 7'b100_0000
    } state_t;

    state_t      state_q, state_d;

    logic        dv_p0;
    logic [7:0]  rxd_p0;

    logic [15:0] cnt_q;
    logic [47:0] mac_q;
    logic [7:0]  etype_hi_q;
    logic [3:0]  ihl_q;
    logic [31:0] sip_q;
    logic [7:0]  ulen_hi_q;
    logic [15:0] data_len_q;
    logic [23:0] acc_q;

    logic        rec_en_q;
    logic [31:0] rec_data_q;
    logic        rec_done_q;
    logic [15:0] rec_byte_num_q;
    logic [31:0] src_ip_q;

    logic        eth_ok;
    logic        ip_fail;
    logic [15:0] ip_last;
    logic        data_last;

    // Expected destination-IP byte for IP header bytes 16..19
    function automatic logic [7:0] dip_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    dip_byte = BOARD_IP[31:24];
            2'd1:    dip_byte = BOARD_IP[23:16];
            2'd2:    dip_byte = BOARD_IP[15:8];
            default: dip_byte = BOARD_IP[7:0];
        endcase
    endfunction

    // Final payload word: left-aligned, unused low bytes zero-filled
    function automatic logic [31:0] align_word(input logic [23:0] acc,
                                               input logic [7:0]  b,
                                               input logic [1:0]  pos);
        case (pos)
            2'd0:    align_word = {b, 24'h0};
            2'd1:    align_word = {acc[7:0], b, 16'h0};
            2'd2:    align_word = {acc[15:0], b, 8'h0};
            default: align_word = {acc, b};
        endcase
    endfunction

    // UDP payload length from the 16-bit UDP length field, clamped at zero
    function automatic logic [15:0] payload_len(input logic [15:0] ulen);
        payload_len = (ulen <= 16'd8) ? 16'd0 : ulen - 16'd8;
    endfunction

    assign eth_ok    = ((mac_q == BOARD_MAC) || (mac_q == 48'hffff_ffff_ffff)) &&
                       ({etype_hi_q, rxd_p0} == 16'h0800);
    assign ip_last   = {10'd0, ihl_q, 2'b00} - 16'd1;
    assign ip_fail   = ((cnt_q == 16'd0) && ((rxd_p0[7:4] != 4'd4) || (rxd_p0[3:0] < 4'd5))) ||
                       ((cnt_q == 16'd9) && (rxd_p0 != 8'd17)) ||
                       ((cnt_q >= 16'd16) && (cnt_q <= 16'd19) && (rxd_p0 != dip_byte(cnt_q[1:0])));
    assign data_last = ((cnt_q + 16'd1) == data_len_q);

    // Stage p0: register the GMII inputs once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_p0  <= 1'b0;
            rxd_p0 <= 8'h00;
        end else begin
            dv_p0  <= bus.gmii_rx_dv;
            rxd_p0 <= bus.gmii_rxd;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= st_idle;
        else     state_q <= state_d;
    end

    // FSM next state; dv dropping before st_rx_end aborts the frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_idle: begin
                if (dv_p0 && (rxd_p0 == 8'h55)) state_d = st_preamble;
            end
            st_preamble: begin
                if (!dv_p0)                                     state_d = st_idle;
                else if ((rxd_p0 == 8'h55) && (cnt_q < 16'd6))  state_d = st_preamble;
                else if ((rxd_p0 == 8'hd5) && (cnt_q == 16'd6)) state_d = st_eth_head;
                else                                            state_d = st_rx_end;
            end
            st_eth_head: begin
                if (!dv_p0)                 state_d = st_idle;
                else if (cnt_q == 16'd13)   state_d = eth_ok ? st_ip_head : st_rx_end;
            end
            st_ip_head: begin
                if (!dv_p0)                 state_d = st_idle;
                else if (ip_fail)           state_d = st_rx_end;
                else if (cnt_q == ip_last)  state_d = st_udp_head;
            end
            st_udp_head: begin
                if (!dv_p0)                 state_d = st_idle;
                else if (cnt_q == 16'd7)    state_d = (data_len_q == 16'd0) ? st_rx_end : st_rx_data;
            end
            st_rx_data: begin
                if (!dv_p0)                 state_d = st_idle;
                else if (data_last)         state_d = st_rx_end;
            end
            st_rx_end: begin
                if (!dv_p0)                 state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase
    end

    // Per-state byte counter and header field capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            mac_q      <= '0;
            etype_hi_q <= '0;
            ihl_q      <= '0;
            sip_q      <= '0;
            ulen_hi_q  <= '0;
            data_len_q <= '0;
            acc_q      <= '0;
        end else begin
            if (state_d != state_q)
                cnt_q <= '0;
            else if ((state_q != st_idle) && (state_q != st_rx_end))
                cnt_q <= cnt_q + 16'd1;

            if (dv_p0) begin
                case (state_q)
                    st_eth_head: begin
                        if (cnt_q < 16'd6)   mac_q      <= {mac_q[39:0], rxd_p0};
                        if (cnt_q == 16'd12) etype_hi_q <= rxd_p0;
                    end
                    st_ip_head: begin
                        if (cnt_q == 16'd0) ihl_q <= rxd_p0[3:0];
                        if ((cnt_q >= 16'd12) && (cnt_q <= 16'd15))
                            sip_q <= {sip_q[23:0], rxd_p0};
                    end
                    st_udp_head: begin
                        if (cnt_q == 16'd4) ulen_hi_q  <= rxd_p0;
                        if (cnt_q == 16'd5) data_len_q <= payload_len({ulen_hi_q, rxd_p0});
                    end
                    st_rx_data: acc_q <= {acc_q[15:0], rxd_p0};
                    default: ;
                endcase
            end
        end
    end

    // Stage p1: output register for payload words, done pulse, count and source IP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_en_q       <= 1'b0;
            rec_data_q     <= '0;
            rec_done_q     <= 1'b0;
            rec_byte_num_q <= '0;
            src_ip_q       <= '0;
        end else begin
            rec_en_q   <= 1'b0;
            rec_done_q <= 1'b0;
            if (dv_p0 && (state_q == st_udp_head)) begin
                if (cnt_q == 16'd5) rec_byte_num_q <= payload_len({ulen_hi_q, rxd_p0});
                if (cnt_q == 16'd7) begin
                    src_ip_q <= sip_q;
                    if (data_len_q == 16'd0) rec_done_q <= 1'b1;
                end
            end
            if (dv_p0 && (state_q == st_rx_data)) begin
                if (data_last) begin
                    rec_en_q   <= 1'b1;
                    rec_done_q <= 1'b1;
                    rec_data_q <= align_word(acc_q, rxd_p0, cnt_q[1:0]);
                end else if (cnt_q[1:0] == 2'b11) begin
                    rec_en_q   <= 1'b1;
                    rec_data_q <= {acc_q, rxd_p0};
                end
            end
        end
    end

    assign bus.rec_en       = rec_en_q;
    assign bus.rec_data     = rec_data_q;
    assign bus.rec_pkt_done = rec_done_q;
    assign bus.rec_byte_num = rec_byte_num_q;
    assign bus.src_ip       = src_ip_q;

endmodule
